// File: rtl/t_ff.sv
// ---------------------------------------------------------------------------
// t_ff : parameterised bank of toggle flip-flops
//
// Each bit of q inverts on a rising clk edge while its t bit is high and holds
// otherwise. Bits are fully independent. The default configuration is a
// single-bit T flip-flop.
//
// Parameters
//   WIDTH      number of independent flip-flops (1..64)
//   RESET_VAL  value forced onto q while reset is asserted
//
// Ports
//   clk      in   1      rising-edge clock, the only clock
//   reset_n  in   1      asynchronous reset, ACTIVE-HIGH despite its name
//   t        in   WIDTH  per-bit toggle enable, sampled at the rising edge
//   q        out  WIDTH  flip-flop state, driven straight from the flops
// ---------------------------------------------------------------------------
module t_ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);

   // reset_n is asserted high: a rising reset_n forces q at once, with no
   // clock edge, and a rising clk while it is still high keeps RESET_VAL.
   // XOR with t toggles exactly the enabled bits and holds the rest.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         q <= RESET_VAL;
      end else begin
         // NOTE: non-blocking assignment so every flop samples the pre-edge
         // state of q, which keeps simulation order-independent.
         q <= q ^ t;
      end
   end

endmodule

// File: tb/tb_t_ff.sv
// ---------------------------------------------------------------------------
// tb_t_ff : directed self-checking bench for t_ff
//
// Two instances share one clock: a default single-bit flop and a 4-bit bank
// with RESET_VAL = 4'b1010. Inputs change 1 ns or more after a rising edge;
// outputs are sampled 1 ns after a rising edge or between edges.
// ---------------------------------------------------------------------------
module tb_t_ff;

   logic       clk;
   logic       rst1;
   logic       t1;
   logic       q1;
   logic       rst4;
   logic [3:0] t4;
   logic [3:0] q4;

   int total = 0;
   int bad   = 0;

   t_ff dut1 (
      .clk     (clk),
      .reset_n (rst1),
      .t       (t1),
      .q       (q1)
   );

   t_ff #(
      .WIDTH     (4),
      .RESET_VAL (4'b1010)
   ) dut4 (
      .clk     (clk),
      .reset_n (rst4),
      .t       (t4),
      .q       (q4)
   );

   // 10 ns period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the directed sequence ends long before this.
   initial begin
      #5000;
      $display("FAIL watchdog: bench did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
         $error("comparison %s did not match", tag);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset held with t high ----------------
      rst1 = 1'b1; t1 = 1'b1;
      rst4 = 1'b1; t4 = 4'b1111;
      #1;
      check("rst_q1_t1",  {3'b000, q1}, 4'b0000);
      check("rst_q4_t1",  q4,           4'b1010);
      edge1();                                   // t = 6
      check("rst_q1_e1",  {3'b000, q1}, 4'b0000);
      edge1();                                   // t = 16
      check("rst_q1_e2",  {3'b000, q1}, 4'b0000);
      check("rst_q4_e2",  q4,           4'b1010);

      // ---------------- hold ----------------
      rst1 = 1'b0; t1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge1();
         check($sformatf("hold0_%0d", i), {3'b000, q1}, 4'b0000);
      end
      t1 = 1'b1;
      edge1();
      check("toggle_once", {3'b000, q1}, 4'b0001);
      t1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         edge1();
         check($sformatf("hold1_%0d", i), {3'b000, q1}, 4'b0001);
      end

      // ---------------- back to 0, then continuous toggle ----------------
      t1 = 1'b1;
      edge1();
      check("toggle_to0", {3'b000, q1}, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         edge1();
         check($sformatf("div2_%0d", i), {3'b000, q1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      end

      // ---------------- glitch rejection (q = 0, t low at every edge) ----------------
      t1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 t1 = 1'b1;                           // edge+2 .. edge+5
         #3 t1 = 1'b0;
         edge1();
         check($sformatf("glitch_%0d", i), {3'b000, q1}, 4'b0000);
      end
      // the 4-bit bank ignored every edge so far
      check("q4_still_rst", q4, 4'b1010);

      // ---------------- async reset mid-operation ----------------
      t1 = 1'b1;
      edge1();
      check("pre_async", {3'b000, q1}, 4'b0001);
      t1 = 1'b0;
      #3 rst1 = 1'b1;                            // edge+4, between edges
      #1;
      check("async_rst", {3'b000, q1}, 4'b0000);
      #1 rst1 = 1'b0; t1 = 1'b1;                 // released at edge+6
      edge1();
      check("post_release", {3'b000, q1}, 4'b0001);
      t1 = 1'b0;

      // ---------------- WIDTH = 4 bank ----------------
      rst4 = 1'b0; t4 = 4'b0110;
      edge1();
      check("w4_t0110", q4, 4'b1100);
      t4 = 4'b1111;
      edge1();
      check("w4_t1111", q4, 4'b0011);
      t4 = 4'b0000;
      edge1();
      check("w4_hold", q4, 4'b0011);
      t4 = 4'b1000;
      edge1();
      check("w4_msb", q4, 4'b1011);
      #3 rst4 = 1'b1;                            // async, between edges
      #1;
      check("w4_async", q4, 4'b1010);
      check("w1_indep", {3'b000, q1}, 4'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
